// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg : valid/ready pipeline stage with 2-entry skid, flush, stall counter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int                CTRL_W      = 10,
  parameter int                DATA_W      = 143,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Incoming beat is dropped; a downstream consume this cycle still stands.
      state_d     = S_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_HALF;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        S_HALF: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = S_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d     = S_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d     = S_HALF;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//------------------------------------------------------------------------------
// tb_pipe_stage_reg : directed vector bench for pipe_stage_reg
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   stall_cnt;

  logic          s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [3:0]    s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE({CW{1'b0}}), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE({CW{1'b0}}), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic          vin;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic          er;
    logic [CW-1:0] ectrl;
    logic [DW-1:0] edata;
    logic [15:0]   es;
  } vec_t;

  vec_t vec[40];
  int   nvec = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic vin, input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                     input logic ordy, input logic fl, input logic ev, input logic er,
                     input logic [CW-1:0] ectrl, input logic [DW-1:0] edata, input logic [15:0] es);
    vec[nvec] = '{vin, ctrl, data, ordy, fl, ev, er, ectrl, edata, es};
    nvec++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h3FF; in_data = 16'hFFFF;
    s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_flush = 1'b0; s_out_ready = 1'b0;

    // Inputs under reset must be ignored.
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_out_valid", 0, 32'(out_valid), 32'd0);
    chk("reset_out_ctrl",  0, 32'(out_ctrl),  32'h000);
    chk("reset_in_ready",  0, 32'(in_ready),  32'd1);
    chk("reset_stall_cnt", 0, 32'(stall_cnt), 32'd0);
    chk("reset_out_data",  0, 32'(out_data),  32'd0);

    // Streaming 1..8 at full rate, then drain.
    for (int i = 1; i <= 8; i++)
      add(1, CW'(i), DW'(i), 1, 0, 1, 1, CW'(i), DW'(i), 16'd0);
    add(0, 0, 0, 1, 0, 0, 1, 10'h000, 16'd8, 16'd0);
    // Backpressure: 3 stall cycles once beat 2 is presented.
    add(1, 10'd1, 16'd1, 1, 0, 1, 1, 10'd1, 16'd1, 16'd0);
    add(1, 10'd2, 16'd2, 1, 0, 1, 1, 10'd2, 16'd2, 16'd0);
    add(1, 10'd3, 16'd3, 0, 0, 1, 0, 10'd2, 16'd2, 16'd1);
    add(1, 10'd4, 16'd4, 0, 0, 1, 0, 10'd2, 16'd2, 16'd2);
    add(1, 10'd4, 16'd4, 0, 0, 1, 0, 10'd2, 16'd2, 16'd3);
    add(1, 10'd4, 16'd4, 1, 0, 1, 1, 10'd3, 16'd3, 16'd3);
    add(1, 10'd4, 16'd4, 1, 0, 1, 1, 10'd4, 16'd4, 16'd3);
    add(1, 10'd5, 16'd5, 1, 0, 1, 1, 10'd5, 16'd5, 16'd3);
    add(1, 10'd6, 16'd6, 1, 0, 1, 1, 10'd6, 16'd6, 16'd3);
    add(0, 0, 0, 1, 0, 0, 1, 10'h000, 16'd6, 16'd3);
    // Fill to FULL, then flush with beat 9 on the input.
    add(1, 10'd7, 16'd7, 0, 0, 1, 1, 10'd7, 16'd7, 16'd3);
    add(1, 10'd8, 16'd8, 0, 0, 1, 0, 10'd7, 16'd7, 16'd4);
    add(1, 10'd9, 16'd9, 0, 1, 0, 1, 10'h000, 16'd7, 16'd5);
    add(0, 0, 0, 1, 0, 0, 1, 10'h000, 16'd7, 16'd5);
    add(1, 10'd10, 16'd10, 1, 0, 1, 1, 10'd10, 16'd10, 16'd5);
    add(0, 0, 0, 1, 0, 0, 1, 10'h000, 16'd10, 16'd5);
    // Drain a single beat to empty.
    add(1, 10'h155, 16'h55, 0, 0, 1, 1, 10'h155, 16'h55, 16'd5);
    add(0, 0, 0, 1, 0, 0, 1, 10'h000, 16'h55, 16'd5);

    for (int i = 0; i < nvec; i++) begin
      in_valid = vec[i].vin; in_ctrl = vec[i].ctrl; in_data = vec[i].data;
      out_ready = vec[i].ordy; flush = vec[i].fl;
      tick();
      chk("vec_out_valid", i, 32'(out_valid), 32'(vec[i].ev));
      chk("vec_in_ready",  i, 32'(in_ready),  32'(vec[i].er));
      chk("vec_out_ctrl",  i, 32'(out_ctrl),  32'(vec[i].ectrl));
      chk("vec_out_data",  i, 32'(out_data),  32'(vec[i].edata));
      chk("vec_stall_cnt", i, 32'(stall_cnt), 32'(vec[i].es));
    end
    flush = 1'b0;

    // Mid-operation reset from FULL discards everything.
    in_valid = 1; in_ctrl = 10'd1; in_data = 16'd1; out_ready = 0; tick();
    in_ctrl = 10'd2; in_data = 16'd2; tick();
    chk("pre_rst_in_ready", 0, 32'(in_ready), 32'd0);
    rst = 1; in_ctrl = 10'd3; in_data = 16'd3; tick();
    chk("mid_rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  0, 32'(in_ready),  32'd1);
    chk("mid_rst_out_ctrl",  0, 32'(out_ctrl),  32'h000);
    chk("mid_rst_stall_cnt", 0, 32'(stall_cnt), 32'd0);
    rst = 0; in_valid = 0; out_ready = 1; tick();
    chk("post_rst_out_valid", 0, 32'(out_valid), 32'd0);

    // Saturation with a 4-bit counter.
    s_in_valid = 1; s_in_ctrl = 10'h0A; s_in_data = 16'h0A; s_out_ready = 0; tick();
    s_in_valid = 0;
    chk("sat_out_valid", 0, 32'(s_out_valid), 32'd1);
    chk("sat_start",     0, 32'(s_stall_cnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat_cnt14", k, 32'(s_stall_cnt), 32'd14);
      if (k == 15) chk("sat_cnt15", k, 32'(s_stall_cnt), 32'd15);
      if (k == 20) chk("sat_cnt20", k, 32'(s_stall_cnt), 32'd15);
    end
    chk("sat_hold_data", 0, 32'(s_out_data), 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
